// File: rtl/hyperbus_pkg.sv
// Shared types for the HyperBus write-data path.
package hyperbus_pkg;

  typedef enum logic [1:0] {
    Idle,
    Stream,
    Pad,
    Discard
  } wbuf_state_e;

  localparam int unsigned StatsWidth = 16;

endpackage

// File: rtl/fifo_v3.sv
// Pointer/count FIFO with optional fall-through; head is readable the cycle after a push when FALL_THROUGH=0.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int unsigned CntW = ADDR_DEPTH + 1;

  logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]       cnt_q;
  dtype                  mem_q [DEPTH];
  logic                  stored_empty, bypass, push_en, pop_en;

  assign stored_empty = (cnt_q == '0);
  assign full_o       = (cnt_q == CntW'(DEPTH));
  // In fall-through mode a word pushed and popped while empty never touches storage.
  assign bypass       = FALL_THROUGH && stored_empty && push_i && pop_i;
  assign empty_o      = stored_empty && !(FALL_THROUGH && push_i);
  assign push_en      = push_i && !full_o && !bypass;
  assign pop_en       = pop_i && !stored_empty;
  assign data_o       = (FALL_THROUGH && stored_empty) ? data_i : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + ADDR_DEPTH'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + ADDR_DEPTH'(1);
      if (push_en && !pop_en)      cnt_q <= cnt_q + CntW'(1);
      else if (!push_en && pop_en) cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/hyperbus_wdata_buffer.sv
// Write-word buffer in front of the PHY: enforces per-burst word count (pad/drop) and emits RWDS mask.
// Optional HYPERBUS_WBUF_STATS_EN adds saturating pad/drop counters.
//   state   | meaning
//   Idle    | waiting for tx_start_i; FIFO may still drain
//   Stream  | accepting packer words, counting down remaining
//   Pad     | packer ended early; pushing fully masked words
//   Discard | burst count reached before in_last_i; dropping words
module hyperbus_wdata_buffer
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumPhys     = 2,
  parameter int unsigned Depth       = 4,
  parameter int unsigned BurstLength = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   tx_start_i,
  input  logic [BurstLength-1:0] tx_words_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [16*NumPhys-1:0]  in_data_i,
  input  logic [2*NumPhys-1:0]   in_strb_i,
  input  logic                   in_last_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [16*NumPhys-1:0]  out_data_o,
  output logic [2*NumPhys-1:0]   out_mask_o,
  output logic                   out_last_o,
  output logic                   busy_o,
  output logic                   err_o
`ifdef HYPERBUS_WBUF_STATS_EN
  ,
  output logic [StatsWidth-1:0]  pad_cnt_o,
  output logic [StatsWidth-1:0]  drop_cnt_o
`endif
);

  localparam int unsigned DataW = 16 * NumPhys;
  localparam int unsigned StrbW = 2 * NumPhys;

  typedef struct packed {
    logic             last;
    logic [StrbW-1:0] strb;
    logic [DataW-1:0] data;
  } word_t;

  wbuf_state_e            state_q, state_d;
  logic [BurstLength-1:0] remaining_q, remaining_d;
  logic                   err_q, err_d;
  logic                   in_ready, push, pop, full, empty, rem_one;
  word_t                  push_word, head;

  assign rem_one = (remaining_q == BurstLength'(1));

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    in_ready    = 1'b0;
    push        = 1'b0;
    push_word   = '0;
    err_d       = 1'b0;
    unique case (state_q)
      Idle: begin
        if (tx_start_i) begin
          if (tx_words_i != '0) begin
            remaining_d = tx_words_i;
            state_d     = Stream;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      Stream: begin
        in_ready = !full;
        err_d    = tx_start_i;
        if (in_valid_i && in_ready) begin
          push           = 1'b1;
          push_word.data = in_data_i;
          push_word.strb = in_strb_i;
          push_word.last = rem_one;
          remaining_d    = remaining_q - BurstLength'(1);
          if (rem_one) begin
            if (in_last_i) begin
              state_d = Idle;
            end else begin
              err_d   = 1'b1;
              state_d = Discard;
            end
          end else if (in_last_i) begin
            state_d = Pad;
          end
        end
      end
      Pad: begin
        err_d = tx_start_i;
        if (!full) begin
          push           = 1'b1;
          push_word.last = rem_one;
          remaining_d    = remaining_q - BurstLength'(1);
          if (rem_one) state_d = Idle;
        end
      end
      Discard: begin
        in_ready = 1'b1;
        err_d    = tx_start_i;
        if (in_valid_i && in_last_i) state_d = Idle;
      end
      default: state_d = Idle;
    endcase
    // Flush wins over everything, including the handshake visible this cycle.
    if (clear_i) begin
      state_d     = Idle;
      remaining_d = '0;
      in_ready    = 1'b0;
      push        = 1'b0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= Idle;
      remaining_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      err_q       <= err_d;
    end
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (Depth),
    .dtype        (word_t)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .full_o  (full),
    .empty_o (empty),
    .data_i  (push_word),
    .push_i  (push),
    .data_o  (head),
    .pop_i   (pop)
  );

  assign pop         = out_ready_i && !empty && !clear_i;
  assign in_ready_o  = in_ready;
  assign out_valid_o = !empty;
  // Storage is not reset, so the head is gated to keep outputs at zero while empty.
  assign out_data_o  = empty ? '0 : head.data;
  assign out_mask_o  = empty ? '0 : ~head.strb;
  assign out_last_o  = !empty && head.last;
  assign busy_o      = (state_q != Idle) || !empty;
  assign err_o       = err_q;

`ifdef HYPERBUS_WBUF_STATS_EN
  logic pad_push, drop;

  assign pad_push = push && (state_q == Pad);
  assign drop     = !clear_i && (state_q == Discard) && in_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pad_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else if (clear_i) begin
      pad_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (pad_push && (pad_cnt_o != '1)) pad_cnt_o  <= pad_cnt_o + StatsWidth'(1);
      if (drop && (drop_cnt_o != '1))    drop_cnt_o <= drop_cnt_o + StatsWidth'(1);
    end
  end
`endif

endmodule
